// File: rtl/tile_scroll_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tile_scroll_ctl
//  Purpose  : Falling-tile sequencer. Scrolls a 4x4 playfield at a
//             level-dependent rate, spawns tiles from an LFSR, judges key
//             presses against the lowest pending tile, keeps score.
//  Revision : 1.0  initial release
// ============================================================================
module tile_scroll_ctl #(
    parameter int unsigned P1       = 25_000_000,
    parameter int unsigned P2       = 15_000_000,
    parameter int unsigned P3       = 10_000_000,
    parameter int unsigned PE_START = 15_000_000,
    parameter int unsigned PE_STEP  = 500_000,
    parameter int unsigned PE_MIN   = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  level,
    input  logic        start,
    input  logic [3:0]  key,
    output logic [15:0] rows,
    output logic [13:0] score,
    output logic [1:0]  game_state,
    output logic        over
);
    localparam logic [13:0] c_score_max = 14'd9999;
    localparam logic [7:0]  c_lfsr_seed = 8'hA5;
    localparam logic [31:0] c_p1        = 32'(P1);
    localparam logic [31:0] c_p2        = 32'(P2);
    localparam logic [31:0] c_p3        = 32'(P3);
    localparam logic [31:0] c_pe_start  = 32'(PE_START);
    localparam logic [31:0] c_pe_step   = 32'(PE_STEP);
    localparam logic [31:0] c_pe_min    = 32'(PE_MIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_rows, w_rows_nxt, w_rows_hit;
    logic [13:0] r_score, w_score_nxt;
    logic        r_over, w_over_nxt;
    logic [31:0] r_tick_cnt, w_cnt_nxt;
    logic [31:0] r_period, w_period_nxt;         // period of the running interval
    logic [31:0] r_period_pend, w_pend_nxt;      // period adopted at next wrap
    logic [3:0]  r_hit_grp, w_grp_nxt;
    logic        r_endless, w_endless_nxt;
    logic [7:0]  r_lfsr;
    logic [31:0] w_level_period;
    logic        w_target_valid;
    logic [1:0]  w_target_idx;
    logic [3:0]  w_target;
    logic        w_key_onehot;
    logic        w_hit;
    logic        w_wrong;
    logic        w_start_game;
    logic [3:0]  w_spawn;

    assign rows       = r_rows;
    assign score      = r_score;
    assign game_state = r_state;
    assign over       = r_over;

    assign w_spawn      = 4'b0001 << r_lfsr[1:0];
    assign w_key_onehot = (key != 4'd0) && ((key & (key - 4'd1)) == 4'd0);
    assign w_start_game = start && (r_state != ST_PLAY);
    assign w_target     = r_rows[{w_target_idx, 2'b00} +: 4];
    assign w_hit        = (r_state == ST_PLAY) && w_target_valid && w_key_onehot
                          && ((key & w_target) != 4'd0);
    assign w_wrong      = (r_state == ST_PLAY) && w_target_valid && (key != 4'd0) && !w_hit;

    // Period selected by the level input when a game starts
    always_comb begin
        w_level_period = c_p1;
        case (level)
            2'd0:    w_level_period = c_p1;
            2'd1:    w_level_period = c_p2;
            2'd2:    w_level_period = c_p3;
            default: w_level_period = c_pe_start;
        endcase
    end

    // Locate the lowest non-empty row; it is the only row a key may hit
    always_comb begin
        w_target_valid = 1'b0;
        w_target_idx   = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (r_rows[4*r +: 4] != 4'd0) begin
                w_target_valid = 1'b1;
                w_target_idx   = 2'(r);
            end
        end
    end

    // Playfield after the key is applied; the tick then scrolls this image
    always_comb begin
        w_rows_hit = r_rows;
        if (w_hit) begin
            w_rows_hit[{w_target_idx, 2'b00} +: 4] = 4'd0;
        end
    end

    // Next-state and datapath update: key first, then tick, then start override
    always_comb begin
        w_state_nxt   = r_state;
        w_rows_nxt    = r_rows;
        w_score_nxt   = r_score;
        w_over_nxt    = 1'b0;
        w_cnt_nxt     = r_tick_cnt;
        w_period_nxt  = r_period;
        w_pend_nxt    = r_period_pend;
        w_grp_nxt     = r_hit_grp;
        w_endless_nxt = r_endless;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = 32'd0;
                w_rows_nxt = 16'd0;
            end
            ST_PLAY: begin
                if (w_hit) begin
                    if (r_score != c_score_max) begin
                        w_score_nxt = r_score + 14'd1;
                    end
                    w_grp_nxt = r_hit_grp + 4'd1;
                    if (r_endless && (r_hit_grp == 4'hF)) begin
                        w_pend_nxt = (r_period_pend >= c_pe_min + c_pe_step)
                                   ? (r_period_pend - c_pe_step) : c_pe_min;
                    end
                end
                if (w_wrong) begin
                    w_state_nxt = ST_OVER;
                    w_over_nxt  = 1'b1;
                end else if (r_tick_cnt == r_period - 32'd1) begin
                    w_cnt_nxt    = 32'd0;
                    w_period_nxt = w_pend_nxt;
                    if (w_rows_hit[3:0] != 4'd0) begin
                        w_rows_nxt  = w_rows_hit;
                        w_state_nxt = ST_OVER;
                        w_over_nxt  = 1'b1;
                    end else begin
                        w_rows_nxt = {w_spawn, w_rows_hit[15:4]};
                    end
                end else begin
                    w_cnt_nxt  = r_tick_cnt + 32'd1;
                    w_rows_nxt = w_rows_hit;
                end
            end
            default: begin
            end
        endcase
        if (w_start_game) begin
            w_state_nxt   = ST_PLAY;
            w_rows_nxt    = 16'd0;
            w_score_nxt   = 14'd0;
            w_cnt_nxt     = 32'd0;
            w_grp_nxt     = 4'd0;
            w_period_nxt  = w_level_period;
            w_pend_nxt    = w_level_period;
            w_endless_nxt = (level == 2'd3);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rows        <= 16'd0;
            r_score       <= 14'd0;
            r_over        <= 1'b0;
            r_tick_cnt    <= 32'd0;
            r_period      <= c_p1;
            r_period_pend <= c_p1;
            r_hit_grp     <= 4'd0;
            r_endless     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rows        <= w_rows_nxt;
            r_score       <= w_score_nxt;
            r_over        <= w_over_nxt;
            r_tick_cnt    <= w_cnt_nxt;
            r_period      <= w_period_nxt;
            r_period_pend <= w_pend_nxt;
            r_hit_grp     <= w_grp_nxt;
            r_endless     <= w_endless_nxt;
        end
    end

    // Free-running Fibonacci LFSR, taps 8,6,5,4; never reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_lfsr_seed;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_scroll_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tile_scroll_ctl
//  Purpose  : Scoreboard bench for tile_scroll_ctl with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tile_scroll_ctl;
    localparam int P1 = 8, P2 = 6, P3 = 4, PE_START = 8, PE_STEP = 2, PE_MIN = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  level = 2'd0;
    logic        start = 1'b0;
    logic [3:0]  key   = 4'd0;
    logic [15:0] rows;
    logic [13:0] score;
    logic [1:0]  game_state;
    logic        over;

    tile_scroll_ctl #(
        .P1(P1), .P2(P2), .P3(P3),
        .PE_START(PE_START), .PE_STEP(PE_STEP), .PE_MIN(PE_MIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .level(level), .start(start), .key(key),
        .rows(rows), .score(score), .game_state(game_state), .over(over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rows;
        logic [13:0] score;
        logic [1:0]  gs;
        logic        over;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // ---------------- behavioural model ----------------
    int         m_state;      // 0 idle, 1 play, 2 over
    logic [3:0] m_row[4];     // index 0 = bottom row
    int         m_score;
    int         m_hits;       // unsaturated hit count for the endless speed-up
    int         m_remain;     // play cycles left until the next scroll
    int         m_base;
    bit         m_endless;
    bit         m_over;
    logic [7:0] m_lfsr;
    int         m_ticks;

    function automatic logic [7:0] lfsr_next(logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int level_period(logic [1:0] lv);
        case (lv)
            2'd0:    return P1;
            2'd1:    return P2;
            2'd2:    return P3;
            default: return PE_START;
        endcase
    endfunction

    function automatic int endless_period(int hits);
        int p;
        p = PE_START - PE_STEP * (hits / 16);
        return (p < PE_MIN) ? PE_MIN : p;
    endfunction

    function automatic int target_idx();
        for (int r = 0; r < 4; r++) if (m_row[r] != 4'd0) return r;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_hits = 0; m_remain = P1; m_base = P1;
        m_endless = 1'b0; m_over = 1'b0; m_lfsr = 8'hA5;
        for (int r = 0; r < 4; r++) m_row[r] = 4'd0;
    endtask

    task automatic model_start(logic [1:0] lv);
        for (int r = 0; r < 4; r++) m_row[r] = 4'd0;
        m_score = 0; m_hits = 0; m_endless = (lv == 2'd3);
        m_base = level_period(lv); m_remain = m_base; m_state = 1;
    endtask

    task automatic model_step(bit s, logic [3:0] k, logic [1:0] lv);
        logic [7:0] l_old;
        int         t;
        bit         wrong;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_over = 1'b0;
        l_old  = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        if (m_state == 1) begin
            wrong = 1'b0;
            t = target_idx();
            if (t >= 0 && k != 4'd0) begin
                if ($countones(k) == 1 && (k & m_row[t]) != 4'd0) begin
                    m_row[t] = 4'd0;
                    m_hits++;
                    if (m_score < 9999) m_score++;
                end else begin
                    wrong = 1'b1;
                end
            end
            if (wrong) begin
                m_state = 2; m_over = 1'b1;
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    m_ticks++;
                    m_remain = m_endless ? endless_period(m_hits) : m_base;
                    if (m_row[0] != 4'd0) begin
                        m_state = 2; m_over = 1'b1;
                    end else begin
                        m_row[0] = m_row[1]; m_row[1] = m_row[2]; m_row[2] = m_row[3];
                        m_row[3] = 4'b0001 << l_old[1:0];
                    end
                end
            end
        end else if (s) begin
            model_start(lv);
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(bit s, logic [3:0] k, logic [1:0] lv, bit rn);
        exp_t e;
        bit   falling;
        @(negedge clk);
        falling = rst_n && !rn;
        rst_n = rn; start = s; key = k; level = lv;
        model_step(s, k, lv);
        e.rows  = {m_row[3], m_row[2], m_row[1], m_row[0]};
        e.score = 14'(m_score);
        e.gs    = 2'(m_state);
        e.over  = m_over;
        exp_q.push_back(e);
        if (falling) begin
            #1;
            check("async_rst_rows", 32'(rows), 32'd0);
            check("async_rst_score", 32'(score), 32'd0);
            check("async_rst_state", 32'(game_state), 32'd0);
            check("async_rst_over", 32'(over), 32'd0);
        end
    endtask

    // mode 0: hit only bottom-row tiles; 1: hit any target eagerly;
    // 2: never press; 3: wrong lane; 4: two keys at once
    task automatic play(int mode, int n_ticks, int max_cyc);
        int t0;
        t0 = m_ticks;
        for (int c = 0; c < max_cyc; c++) begin
            logic [3:0] k;
            int         t;
            if (m_state != 1 || (m_ticks - t0) >= n_ticks) break;
            k = 4'd0;
            t = target_idx();
            case (mode)
                0: if (t == 0 && (m_remain == 1 || $urandom_range(0, 3) == 0)) k = m_row[0];
                1: if (t >= 0 && (m_remain == 1 || $urandom_range(0, 1) == 0)) k = m_row[t];
                3: if (t >= 0 && $urandom_range(0, 2) == 0) k = {m_row[t][2:0], m_row[t][3]};
                4: if (t >= 0 && $urandom_range(0, 2) == 0) k = 4'b0011;
                default: k = 4'd0;
            endcase
            drive($urandom_range(0, 31) == 0, k, 2'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rows", 32'(rows), 32'(e.rows));
                check("score", 32'(score), 32'(e.score));
                check("game_state", 32'(game_state), 32'(e.gs));
                check("over", 32'(over), 32'(e.over));
            end
        end
    end

    initial begin
        model_reset();
        m_ticks = 0;
        repeat (3) drive(1'b0, 4'd0, 2'd0, 1'b0);
        repeat (2) drive(1'b0, 4'd0, 2'd0, 1'b1);

        // level 1: perfect play, then a miss, then keys ignored in OVER
        drive(1'b1, 4'd0, 2'd0, 1'b1);
        play(0, 40, 800);
        play(2, 10, 200);
        repeat (6) drive(1'b0, 4'($urandom_range(0, 15)), 2'd0, 1'b1);

        // level 2: keys with an empty field, then wrong lane
        drive(1'b1, 4'd0, 2'd1, 1'b1);
        drive(1'b0, 4'b0100, 2'd0, 1'b1);
        drive(1'b0, 4'b0011, 2'd0, 1'b1);
        play(0, 3, 100);
        play(3, 8, 200);
        repeat (3) drive(1'b0, 4'd0, 2'd0, 1'b1);

        // level 3: two-key press against a valid target
        drive(1'b1, 4'd0, 2'd2, 1'b1);
        play(0, 3, 100);
        play(4, 8, 200);

        // endless: enough hits for three speed-up steps
        drive(1'b1, 4'd0, 2'd3, 1'b1);
        play(1, 64, 1500);

        // reset in the middle of a game
        drive(1'b1, 4'd0, 2'd3, 1'b1);
        play(1, 5, 100);
        repeat (2) drive(1'b0, 4'd0, 2'd0, 1'b0);
        repeat (2) drive(1'b0, 4'd0, 2'd0, 1'b1);

        // random soak
        for (int i = 0; i < 600; i++) begin
            logic [3:0] k;
            k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            drive($urandom_range(0, 39) == 0, k, 2'($urandom_range(0, 3)), 1'b1);
        end
        drive(1'b0, 4'd0, 2'd0, 1'b1);

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
